// File: rtl/control_ff_jk_if.sv
`default_nettype none
// ============================================================================
// Module      : control_ff_jk_if
// Description : Command and flip-flop bank bundle for control_ff_jk.
//               master : lab-board side; issues commands and owns the bank
//                        feedback (start, op, data, steps, q_in).
//               slave  : sequencer side; drives the bank J/K inputs and
//                        reports status (j_out, k_out, busy, done, err).
// Revision    : 1.0 - initial release
// ============================================================================
interface control_ff_jk_if #(
    parameter int N  = 4,
    parameter int SW = 8
);
    logic          start;
    logic [2:0]    op;
    logic [N-1:0]  data;
    logic [SW-1:0] steps;
    logic [N-1:0]  q_in;
    logic [N-1:0]  j_out;
    logic [N-1:0]  k_out;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, op, data, steps, q_in,
        input  j_out, k_out, busy, done, err
    );

    modport slave (
        input  start, op, data, steps, q_in,
        output j_out, k_out, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/control_ff_jk.sv
`default_nettype none
// ============================================================================
// Module      : control_ff_jk
// Description : Sequencer for a bank of N external JK flip-flops. Accepts one
//               command (hold, clear, set, toggle, load, count, verify) per
//               start/busy/done handshake, drives the bank J/K inputs, then
//               checks the fed-back Q vector and flags mismatches on err.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - control_ff_jk_if.slave (start/op/data/steps/q_in in,
//                      j_out/k_out/busy/done/err out)
// Revision    : 1.0 - initial release
// ============================================================================
module control_ff_jk #(
    parameter int N  = 4,
    parameter int SW = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    control_ff_jk_if.slave bus
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_apply  = 3'd1;
    localparam logic [2:0] c_st_settle = 3'd2;
    localparam logic [2:0] c_st_check  = 3'd3;
    localparam logic [2:0] c_st_fin    = 3'd4;

    localparam logic [2:0] c_op_hold   = 3'd0;
    localparam logic [2:0] c_op_clear  = 3'd1;
    localparam logic [2:0] c_op_set    = 3'd2;
    localparam logic [2:0] c_op_toggle = 3'd3;
    localparam logic [2:0] c_op_load   = 3'd4;
    localparam logic [2:0] c_op_count  = 3'd5;
    localparam logic [2:0] c_op_verify = 3'd6;
    localparam logic [2:0] c_op_bad    = 3'd7;

    localparam logic [SW-1:0] c_cnt_one = SW'(1);

    logic [2:0]    r_state;
    logic [2:0]    r_op;
    logic [N-1:0]  r_data;
    logic [N-1:0]  r_q0;
    logic [N-1:0]  r_steps_n;
    logic [SW-1:0] r_cnt;
    logic [N-1:0]  r_j;
    logic [N-1:0]  r_k;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic [N-1:0]  w_q_next;
    logic [N-1:0]  w_carry;
    logic [N-1:0]  w_steps_n;
    logic [N-1:0]  w_expect;
    logic [2*N-1:0] w_drive_acc;

    // STEPS reduced to the counter width, so the expected count wraps mod 2^N.
    generate
        if (SW >= N) begin : g_steps_trunc
            assign w_steps_n = bus.steps[N-1:0];
        end else begin : g_steps_ext
            assign w_steps_n = {{(N-SW){1'b0}}, bus.steps};
        end
    endgenerate

    // The bank captures J/K on the same edge this block does, so the value
    // sampled on q_in is one step stale. Predict the bank's next Q from the
    // J/K currently being driven and derive the counter carries from that.
    assign w_q_next = (r_j & ~bus.q_in) | (~r_k & bus.q_in);

    always_comb begin
        w_carry    = '0;
        w_carry[0] = 1'b1;
        for (int i = 1; i < N; i++) begin
            w_carry[i] = w_carry[i-1] & w_q_next[i-1];
        end
    end

    // J/K pattern for the first APPLY cycle, as {j, k}.
    function automatic logic [2*N-1:0] f_drive(
        input logic [2:0]   op,
        input logic [N-1:0] d,
        input logic [N-1:0] carry
    );
        logic [N-1:0] j;
        logic [N-1:0] k;
        j = '0;
        k = '0;
        case (op)
            c_op_clear:  k = '1;
            c_op_set:    j = '1;
            c_op_toggle: begin j = '1; k = '1; end
            c_op_load:   begin j = d;  k = ~d; end
            c_op_count:  begin j = carry; k = carry; end
            default:     begin j = '0; k = '0; end
        endcase
        return {j, k};
    endfunction

    assign w_drive_acc = f_drive(bus.op, bus.data, w_carry);

    always_comb begin
        w_expect = r_q0;
        case (r_op)
            c_op_hold:   w_expect = r_q0;
            c_op_clear:  w_expect = '0;
            c_op_set:    w_expect = '1;
            c_op_toggle: w_expect = ~r_q0;
            c_op_load:   w_expect = r_data;
            c_op_verify: w_expect = r_data;
            c_op_count:  w_expect = r_q0 + r_steps_n;
            default:     w_expect = r_q0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_op      <= '0;
            r_data    <= '0;
            r_q0      <= '0;
            r_steps_n <= '0;
            r_cnt     <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // J/K and done are only held for the cycle in which they are set.
            r_j    <= '0;
            r_k    <= '0;
            r_done <= 1'b0;
            case (r_state)
                c_st_idle, c_st_fin: begin
                    if (bus.start) begin
                        r_op      <= bus.op;
                        r_data    <= bus.data;
                        r_steps_n <= w_steps_n;
                        r_cnt     <= bus.steps;
                        r_q0      <= bus.q_in;
                        r_err     <= 1'b0;
                        if (bus.op == c_op_bad) begin
                            r_state <= c_st_fin;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (bus.op == c_op_count && bus.steps == '0) begin
                            r_state <= c_st_settle;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= c_st_apply;
                            r_busy  <= 1'b1;
                            r_j     <= w_drive_acc[2*N-1:N];
                            r_k     <= w_drive_acc[N-1:0];
                        end
                    end else begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end
                end
                c_st_apply: begin
                    if (r_op == c_op_count && r_cnt > c_cnt_one) begin
                        r_cnt <= r_cnt - c_cnt_one;
                        r_j   <= w_carry;
                        r_k   <= w_carry;
                    end else begin
                        r_state <= c_st_settle;
                    end
                end
                c_st_settle: begin
                    r_state <= c_st_check;
                end
                c_st_check: begin
                    if (bus.q_in != w_expect) begin
                        r_err <= 1'b1;
                    end
                    r_state <= c_st_fin;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.j_out = r_j;
    assign bus.k_out = r_k;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: doc/control_ff_jk.md
Name: control_ff_jk

Overview:
- Sequencer for a bank of N external JK flip-flops.
- Accepts one command at a time through a START/BUSY/DONE handshake and drives the per-bit J/K vectors for that command: hold, clear, set, toggle, parallel load, or synchronous binary counting.
- Reads back the Q vector, checks it against the expected result and flags any mismatch on ERR.
- Sits between the lab-board control logic and the JK flip-flop register it owns.

Parameters:
- N, 4, number of JK flip-flops controlled (1..16).
- SW, 8, width of the STEPS count field.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  command strobe; sampled only when BUSY=0.
- OP  input  3  command code: 0 HOLD, 1 CLEAR, 2 SET, 3 TOGGLE, 4 LOAD, 5 COUNT, 6 VERIFY, 7 illegal.
- DATA  input  N  load value (LOAD) or compare value (VERIFY).
- STEPS  input  SW  number of count clocks (COUNT only).
- Q_IN  input  N  Q outputs fed back from the flip-flop bank.
- J_OUT  output  N  J inputs of the flip-flop bank.
- K_OUT  output  N  K inputs of the flip-flop bank.
- BUSY  output  1  command in progress.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  result mismatch or illegal opcode; sticky until the next accepted START.

Behaviour:
- Reset:
  - Takes effect at the next CLK edge with RST=1, including mid-command.
  - State goes to IDLE; J_OUT=0, K_OUT=0, BUSY=0, DONE=0, ERR=0.
  - All latched fields clear. No J/K activity leaks after the reset edge.
- States: IDLE, APPLY, SETTLE, CHECK, FIN.
- Acceptance:
  - START=1 in IDLE or FIN is accepted at the edge.
  - OP, DATA and STEPS are latched and ERR clears.
  - Q_IN is captured as Q0.
  - Next state is APPLY; an illegal OP goes to FIN instead.
  - START during BUSY=1 is ignored.
- APPLY (BUSY=1), J/K drive per opcode:
  - HOLD: J=K=0.
  - CLEAR: J=0, K=all 1.
  - SET: J=all 1, K=0.
  - TOGGLE: J=K=all 1.
  - LOAD: J=DATA, K=~DATA.
  - VERIFY: J=K=0.
  - COUNT: J[i]=K[i]=AND of Q_IN[i-1:0], with bit 0 = 1 (live feedback every cycle).
- APPLY duration:
  - One cycle for all opcodes except COUNT.
  - COUNT stays in APPLY for exactly STEPS cycles, tracked by an internal down-counter.
  - COUNT with STEPS=0 skips APPLY and goes to SETTLE.
- SETTLE (BUSY=1): J=K=0 for one cycle so Q_IN is stable.
- CHECK (BUSY=1), J=K=0. Expected value E:
  - HOLD: Q0.
  - CLEAR: 0.
  - SET: all 1.
  - TOGGLE: ~Q0.
  - LOAD and VERIFY: DATA.
  - COUNT: (Q0+STEPS) mod 2^N.
  - ERR is set if Q_IN != E.
- FIN: BUSY=0, DONE=1 for exactly one cycle, J=K=0. Returns to IDLE unless a new START is accepted.
- Latency from the accepting edge to DONE high:
  - 4 cycles for non-COUNT opcodes.
  - STEPS+3 cycles for COUNT with STEPS≥1; 3 cycles for STEPS=0.
  - 1 cycle for an illegal opcode, which returns DONE=1, ERR=1 and never drives J/K.
- Count wrap: all-ones wraps to 0 naturally; the expected value uses modulo-2^N arithmetic, width N, with STEPS truncated to N bits.
- J_OUT and K_OUT are registered and are 0 in every state except APPLY.
- Simultaneous RST and START: RST wins.

Test Plan:
- RST=1 for 2 cycles mid-COUNT (N=4, STEPS=10) → next cycle J_OUT=K_OUT=0, BUSY=0, DONE=0, ERR=0; the bank stops changing.
- Q=4'b0101, OP=LOAD, DATA=4'b1010 → one APPLY cycle with J=1010, K=0101; DONE 4 cycles after acceptance; Q=1010, ERR=0.
- Q=4'b1110, OP=COUNT, STEPS=3 → Q sequence 1111, 0000, 0001; DONE at cycle 6; ERR=0 (wrap verified).
- OP=TOGGLE from Q=0011 → Q=1100, ERR=0. Then VERIFY with DATA=0000 → ERR=1, DONE pulse. Next accepted START clears ERR.
- OP=7 → DONE=1 and ERR=1 on the cycle after acceptance; J/K stay 0. START asserted while BUSY during a COUNT STEPS=5 → ignored, Q ends at Q0+5.
- COUNT STEPS=0 → no J/K activity, DONE at cycle 3, ERR=0. Back-to-back START on the FIN cycle is accepted with no idle gap.
